// File: rtl/alu.sv
// alu: unsigned WIDTH-bit arithmetic/logic unit with registered result and carry.
// One operation is captured on every rising clock edge; latency is one cycle.
module alu #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpNot = 3'b100;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // Widened add/subtract; the top bit is carry for add and borrow (A < B) for subtract.
  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    diff = {1'b0, A} - {1'b0, B};
  end

  // Next-state select. Reserved and unknown opcodes fall to the all-zero default,
  // and NOT/default never read B so an unknown B cannot reach the registers.
  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    case (opcode)
      OpAdd: begin
        result_d = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
      end
      OpSub: begin
        result_d = diff[WIDTH-1:0];
        carry_d  = diff[WIDTH];
      end
      OpAnd:   result_d = A & B;
      OpOr:    result_d = A | B;
      OpNot:   result_d = ~A;
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears them immediately, independent of the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for the 4-bit alu.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] opcode;
  logic [3:0] result;
  logic       carry_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs currently held by the registers.
  logic [3:0] prev_r;
  logic       prev_c;

  alu #(
    .WIDTH(4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .A        (a),
    .B        (b),
    .opcode   (opcode),
    .result   (result),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one vector after a falling edge, confirm the old value still holds before the
  // rising edge, then confirm the new value appears just after it.
  task automatic run_vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                         input logic [2:0] vop, input logic [3:0] exp_r, input logic exp_c);
    @(negedge clk);
    a      = va;
    b      = vb;
    opcode = vop;
    #1;
    check_eq({tag, "_hold_r"}, {28'd0, result}, {28'd0, prev_r});
    check_eq({tag, "_hold_c"}, {31'd0, carry_out}, {31'd0, prev_c});
    @(posedge clk);
    #1;
    check_eq({tag, "_r"}, {28'd0, result}, {28'd0, exp_r});
    check_eq({tag, "_c"}, {31'd0, carry_out}, {31'd0, exp_c});
    prev_r = exp_r;
    prev_c = exp_c;
  endtask

  initial begin
    rst    = 1'b1;
    a      = 4'h0;
    b      = 4'h0;
    opcode = 3'b000;
    prev_r = 4'h0;
    prev_c = 1'b0;

    #2;
    check_eq("reset_r", {28'd0, result}, 32'd0);
    check_eq("reset_c", {31'd0, carry_out}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("reset_edge_r", {28'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_vec("add",      4'b0011, 4'b0001, 3'b000, 4'b0100, 1'b0);
    run_vec("add_ovf",  4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1);
    run_vec("sub",      4'b0100, 4'b0010, 3'b001, 4'b0010, 1'b0);
    run_vec("sub_brw",  4'b0010, 4'b0100, 3'b001, 4'b1110, 1'b1);
    run_vec("and",      4'b1100, 4'b1010, 3'b010, 4'b1000, 1'b0);
    run_vec("or",       4'b1100, 4'b1010, 3'b011, 4'b1110, 1'b0);
    run_vec("not",      4'b1100, 4'bxxxx, 3'b100, 4'b0011, 1'b0);
    check_eq("not_known", {31'd0, $isunknown({result, carry_out})}, 32'd0);
    run_vec("rsv111_0", 4'b0000, 4'b0000, 3'b111, 4'b0000, 1'b0);
    run_vec("rsv101",   4'b1111, 4'b1111, 3'b101, 4'b0000, 1'b0);
    run_vec("rsv110",   4'b1111, 4'b1111, 3'b110, 4'b0000, 1'b0);
    run_vec("rsv111",   4'b1111, 4'b1111, 3'b111, 4'b0000, 1'b0);
    run_vec("rsv_bx",   4'b1010, 4'bxxxx, 3'b110, 4'b0000, 1'b0);
    check_eq("rsv_known", {31'd0, $isunknown({result, carry_out})}, 32'd0);

    // Back-to-back opcode changes every cycle.
    run_vec("b2b_add",  4'b0111, 4'b1000, 3'b000, 4'b1111, 1'b0);
    run_vec("b2b_sub",  4'b0000, 4'b0001, 3'b001, 4'b1111, 1'b1);
    run_vec("b2b_add2", 4'b1000, 4'b1000, 3'b000, 4'b0000, 1'b1);
    run_vec("b2b_sub0", 4'b0101, 4'b0101, 3'b001, 4'b0000, 1'b0);
    run_vec("b2b_and",  4'b0110, 4'b0011, 3'b010, 4'b0010, 1'b0);
    run_vec("b2b_or",   4'b0100, 4'b0001, 3'b011, 4'b0101, 1'b0);
    run_vec("b2b_not",  4'b0000, 4'b1111, 3'b100, 4'b1111, 1'b0);
    run_vec("b2b_add3", 4'b1001, 4'b1001, 3'b000, 4'b0010, 1'b1);

    // Mid-stream asynchronous reset: outputs clear without a clock edge.
    @(negedge clk);
    a      = 4'b0011;
    b      = 4'b0001;
    opcode = 3'b000;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_r", {28'd0, result}, 32'd0);
    check_eq("midrst_c", {31'd0, carry_out}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("midrst_edge_r", {28'd0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("postrst_r", {28'd0, result}, 32'h4);
    check_eq("postrst_c", {31'd0, carry_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Parameterized-width arithmetic logic unit with registered outputs. It performs one of five operations on two unsigned operands, selected by a 3-bit opcode: add, subtract, AND, OR, NOT. It is a leaf datapath block. Upstream logic drives operands and opcode; downstream logic samples `result` and `carry_out` one clock later.

## Interface
Parameters:
- `WIDTH`, default 4, operand and result width in bits (minimum 1).

Ports:
- `clk`  input  1  single system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `A`  input  WIDTH  operand A, unsigned.
- `B`  input  WIDTH  operand B, unsigned; ignored for logic-NOT and reserved opcodes.
- `opcode`  input  3  operation select.
- `result`  output  WIDTH  registered operation result.
- `carry_out`  output  1  registered carry/borrow flag.

## Operation
Opcode map:
- 000 ADD: {carry_out, result} = A + B, computed at WIDTH+1 bits; carry_out = bit WIDTH of the sum.
- 001 SUB: result = (A − B) mod 2^WIDTH. carry_out = borrow: 1 when A < B unsigned, else 0.
- 010 AND: result = A & B; carry_out = 0.
- 011 OR: result = A | B; carry_out = 0.
- 100 NOT: result = ~A; carry_out = 0.
- 101, 110, 111 reserved (default case): result = 0; carry_out = 0.

Arithmetic and input-handling rules:
- All arithmetic is unsigned.
- There is no overflow flag other than carry_out.
- Results wrap modulo 2^WIDTH.
- For NOT and the reserved opcodes, B has no influence on the outputs. If B is X or Z under those opcodes, result and carry_out must still be fully known (0/1).
- An X or Z opcode must never latch into the registers as a valid op. The reserved default (result 0, carry_out 0) applies.
- The combinational next-state is computed every cycle. There is no enable and no handshake: every rising edge captures a new result.

## Timing
- Latency is exactly 1 cycle. Inputs present before rising edge N appear on `result`/`carry_out` after edge N and hold until edge N+1.
- Throughput is 1 operation per cycle. Back-to-back opcode changes are allowed every cycle.
- Reset:
  - While `rst` = 1, result = 0 and carry_out = 0, regardless of `clk`.
  - Asserting `rst` clears the outputs immediately, without waiting for an edge, including mid-stream.
  - After `rst` deasserts, the first rising edge captures the current inputs.
- There are no internal state machines. The output registers are the only state.

## Test plan
- Reset: drive `rst`=1 mid-run with A=0011, B=0001, opcode=000 → result=0000 and carry_out=0 immediately. After release, the next edge gives result=0100, carry_out=0.
- ADD:
  - A=0011, B=0001, op=000 → result=0100, carry_out=0.
  - Overflow case: A=1111, B=0001 → result=0000, carry_out=1.
- SUB:
  - A=0100, B=0010, op=001 → result=0010, carry_out=0.
  - Borrow case: A=0010, B=0100 → result=1110, carry_out=1.
- Logic:
  - A=1100, B=1010, op=010 → result=1000, carry_out=0.
  - Same operands, op=011 → result=1110, carry_out=0.
- NOT: A=1100, B=xxxx, op=100 → result=0011, carry_out=0, with no X on either output.
- Reserved opcodes and latency:
  - A=0000, B=0000, op=111 → result=0000, carry_out=0.
  - Repeat with A=1111, B=1111 for op=101/110/111 → result=0000, carry_out=0.
  - Change the opcode every cycle and confirm each result appears exactly one edge later.
